// File: rtl/mac_mdc_par_pkg.sv
// mac_par_package: shared FSM/mode encodings and width helpers for the multi-lane MAC engine.
// Latency: none, declarations only.
// Backpressure: not applicable.
package mac_par_package;

  typedef enum logic [2:0] {IDLE, LOAD_C, STREAM, OUT, DONE} state_t;
  typedef enum logic {DOT = 1'b0, ACC = 1'b1} mode_t;

  // Full-precision signed product of two elements
  function automatic int PROD_W(input int data_w);
    return 2 * data_w;
  endfunction

  // Lane reduction grows by one bit per tree level
  function automatic int SUM_W(input int data_w, input int nb_lanes);
    return 2 * data_w + $clog2(nb_lanes);
  endfunction

  // Accumulator holds up to 2**cnt_w - 1 sums plus the seed without overflow
  function automatic int ACC_W(input int data_w, input int nb_lanes, input int cnt_w);
    return SUM_W(data_w, nb_lanes) + cnt_w;
  endfunction

endpackage

// File: rtl/mac_mdc_par_dotp.sv
// mac_par_dotp: per-lane signed multiply (S1) then lane reduction (S2), both elastic stages.
// Latency: 2 cycles from in handshake to out_vld.
// Backpressure: each stage holds while full and downstream not ready; in_rdy = S1 can advance.
module mac_par_dotp
  import mac_par_package::*;
#(
  parameter int   DATA_W   = 32,
  parameter int   NB_LANES = 4,
  localparam int  PW       = PROD_W(DATA_W),
  localparam int  SW       = SUM_W(DATA_W, NB_LANES)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         clear,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [NB_LANES*DATA_W-1:0]   a_dat,
  input  logic [NB_LANES*DATA_W-1:0]   b_dat,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic signed [SW-1:0]         out_dat,
  output logic                         pipe_busy
);

  logic signed [PW-1:0] prod_d [NB_LANES];
  logic signed [PW-1:0] prod_q [NB_LANES];
  logic signed [SW-1:0] sum_d;
  logic                 s1_vld;
  logic                 s1_rdy;
  logic                 s2_rdy;

  assign s2_rdy    = ~out_vld | out_rdy;
  assign s1_rdy    = ~s1_vld | s2_rdy;
  assign in_rdy    = s1_rdy;
  assign pipe_busy = s1_vld | out_vld;

  // Sign-extend each lane to product width before multiplying so the product is exact
  always_comb begin
    for (int i = 0; i < NB_LANES; i++) begin
      prod_d[i] = PW'($signed(a_dat[i*DATA_W +: DATA_W])) * PW'($signed(b_dat[i*DATA_W +: DATA_W]));
    end
  end

  // Reduce the registered products; synthesis balances the chain into a tree
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NB_LANES; i++) begin
      sum_d = sum_d + SW'(prod_q[i]);
    end
  end

  // S1 product register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld <= 1'b0;
      for (int i = 0; i < NB_LANES; i++) prod_q[i] <= '0;
    end else if (clear) begin
      s1_vld <= 1'b0;
      for (int i = 0; i < NB_LANES; i++) prod_q[i] <= '0;
    end else if (s1_rdy) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        for (int i = 0; i < NB_LANES; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // S2 sum register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (clear) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (s2_rdy) begin
      out_vld <= s1_vld;
      if (s1_vld) out_dat <= sum_d;
    end
  end

endmodule

// File: rtl/mac_mdc_par.sv
// mac_mdc_par: multi-lane signed MAC engine; DOT emits one result per beat, ACC one per job.
// Latency: 3 cycles a/b handshake to d_TVALID in DOT; ACC emits after the last sum is folded.
// Backpressure: d_TREADY low stalls S3, then S2/S1, then a/b TREADY; nothing dropped or duplicated.
module mac_mdc_par
  import mac_par_package::*;
#(
  parameter int DATA_W   = 32,
  parameter int NB_LANES = 4,
  parameter int CNT_W    = 10
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         a_TVALID,
  output logic                         a_TREADY,
  input  logic [NB_LANES*DATA_W-1:0]   a_TDATA,
  input  logic                         b_TVALID,
  output logic                         b_TREADY,
  input  logic [NB_LANES*DATA_W-1:0]   b_TDATA,
  input  logic                         c_TVALID,
  output logic                         c_TREADY,
  input  logic [DATA_W-1:0]            c_TDATA,
  output logic                         d_TVALID,
  input  logic                         d_TREADY,
  output logic [DATA_W-1:0]            d_TDATA,
  input  logic                         start,
  input  logic                         reg_clear,
  input  logic                         reg_mode,
  input  logic                         reg_sat,
  input  logic [$clog2(DATA_W)-1:0]    reg_shift,
  input  logic [CNT_W-1:0]             reg_len,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_W-1:0]             cnt_o
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int SW   = SUM_W(DATA_W, NB_LANES);
  localparam int AW   = ACC_W(DATA_W, NB_LANES, CNT_W);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  state_t               state;
  mode_t                mode_q;
  logic                 sat_q;
  logic [SH_W-1:0]      shift_q;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sum_ext;
  logic signed [AW-1:0] c_ext;
  logic                 d_vld;
  logic [DATA_W-1:0]    d_dat;
  logic                 accept;
  logic                 fire;
  logic                 pipe_in_rdy;
  logic                 pipe_vld;
  logic                 pipe_rdy;
  logic                 pipe_busy;
  logic signed [SW-1:0] pipe_dat;

  // Arithmetic right shift, then clamp or truncate to the element width
  function automatic logic [DATA_W-1:0] fmt(input logic signed [AW-1:0] v,
                                            input logic [SH_W-1:0] sh, input logic sat);
    logic signed [AW-1:0] r;
    r = v >>> sh;
    if (sat) begin
      if (r > MAXV)      r = MAXV;
      else if (r < MINV) r = MINV;
    end
    return r[DATA_W-1:0];
  endfunction

  assign accept   = (state == STREAM) && (cnt < len_q) && pipe_in_rdy;
  assign fire     = accept & a_TVALID & b_TVALID;
  assign a_TREADY = accept & b_TVALID;
  assign b_TREADY = accept & a_TVALID;
  assign c_TREADY = (state == LOAD_C);
  assign pipe_rdy = (mode_q == DOT) ? (~d_vld | d_TREADY) : 1'b1;
  assign sum_ext  = {{(AW-SW){pipe_dat[SW-1]}}, pipe_dat};
  assign c_ext    = {{(AW-DATA_W){c_TDATA[DATA_W-1]}}, c_TDATA};
  assign d_TVALID = d_vld;
  assign d_TDATA  = d_dat;
  assign busy_o   = (state != IDLE);
  assign cnt_o    = cnt;

  mac_par_dotp #(
    .DATA_W   (DATA_W),
    .NB_LANES (NB_LANES)
  ) u_dotp (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .clear     (reg_clear),
    .in_vld    (fire),
    .in_rdy    (pipe_in_rdy),
    .a_dat     (a_TDATA),
    .b_dat     (b_TDATA),
    .out_vld   (pipe_vld),
    .out_rdy   (pipe_rdy),
    .out_dat   (pipe_dat),
    .pipe_busy (pipe_busy)
  );

  // Control FSM plus S3 (DOT output register / ACC fold) and registered status outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE; mode_q <= DOT; sat_q <= 1'b0; shift_q <= '0; len_q <= '0;
      cnt <= '0; acc <= '0; d_vld <= 1'b0; d_dat <= '0; done_o <= 1'b0;
    end else if (reg_clear) begin
      state <= IDLE; mode_q <= DOT; sat_q <= 1'b0; shift_q <= '0; len_q <= '0;
      cnt <= '0; acc <= '0; d_vld <= 1'b0; d_dat <= '0; done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (fire) cnt <= cnt + CNT_W'(1);
      if (mode_q == DOT) begin
        if (pipe_rdy) begin
          d_vld <= pipe_vld;
          if (pipe_vld) d_dat <= fmt(sum_ext, shift_q, sat_q);
        end
      end else if (pipe_vld) begin
        acc <= acc + sum_ext;
      end
      case (state)
        IDLE: begin
          if (start) begin
            mode_q  <= mode_t'(reg_mode);
            sat_q   <= reg_sat;
            shift_q <= reg_shift;
            len_q   <= reg_len;
            cnt     <= '0;
            if (reg_len == '0)  state <= DONE;
            else if (reg_mode)  state <= LOAD_C;
            else                state <= STREAM;
          end
        end
        LOAD_C: begin
          if (c_TVALID) begin
            acc   <= c_ext <<< shift_q;
            state <= STREAM;
          end
        end
        STREAM: begin
          // DOT drains through the output register; ACC only needs the last fold done
          if (cnt == len_q && !pipe_busy) begin
            if (mode_q == DOT) begin
              if (!d_vld) state <= DONE;
            end else begin
              d_vld <= 1'b1;
              d_dat <= fmt(acc, shift_q, sat_q);
              state <= OUT;
            end
          end
        end
        OUT: begin
          if (d_TREADY) begin
            d_vld <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_mdc_par.sv
// tb_mac_mdc_par: directed bench for mac_mdc_par with a queue scoreboard and arithmetic model.
// Latency: d results are matched in order against the expected queue on every handshake.
// Backpressure: a window of d_TREADY low checks holding of d and stalling of a/b.
module tb_mac_mdc_par;

  logic         ap_clk;
  logic         ap_rst_n;
  logic         a_TVALID, a_TREADY, b_TVALID, b_TREADY;
  logic [127:0] a_TDATA, b_TDATA;
  logic         c_TVALID, c_TREADY;
  logic [31:0]  c_TDATA;
  logic         d_TVALID, d_TREADY;
  logic [31:0]  d_TDATA;
  logic         start, reg_clear, reg_mode, reg_sat;
  logic [4:0]   reg_shift;
  logic [9:0]   reg_len;
  logic         busy_o, done_o;
  logic [9:0]   cnt_o;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  bit stall_en = 0;
  int stall_cnt = 0;
  logic [31:0] exp_q[$];

  mac_mdc_par dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .a_TVALID(a_TVALID), .a_TREADY(a_TREADY), .a_TDATA(a_TDATA),
    .b_TVALID(b_TVALID), .b_TREADY(b_TREADY), .b_TDATA(b_TDATA),
    .c_TVALID(c_TVALID), .c_TREADY(c_TREADY), .c_TDATA(c_TDATA),
    .d_TVALID(d_TVALID), .d_TREADY(d_TREADY), .d_TDATA(d_TDATA),
    .start(start), .reg_clear(reg_clear), .reg_mode(reg_mode), .reg_sat(reg_sat),
    .reg_shift(reg_shift), .reg_len(reg_len),
    .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Dot product of four signed lanes, arithmetic shift, then clamp or keep low 32 bits
  function automatic logic [31:0] model_d(input logic [127:0] a, input logic [127:0] b,
                                          input int sh, input bit sat);
    logic signed [127:0] s, r, hi, lo;
    s = 0;
    for (int i = 0; i < 4; i++)
      s = s + 128'($signed(a[i*32 +: 32])) * 128'($signed(b[i*32 +: 32]));
    r  = s >>> sh;
    hi = 128'sd2147483647;
    lo = -hi - 1;
    if (sat) begin
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
    end
    return r[31:0];
  endfunction

  // All tasks start and end 1 time unit after a rising edge
  task automatic pulse_start(input bit mode, input bit sat, input int sh, input int len);
    reg_mode  = mode;
    reg_sat   = sat;
    reg_shift = 5'(sh);
    reg_len   = 10'(len);
    start     = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic send_ab(input logic [127:0] av, input logic [127:0] bv);
    bit ok;
    ok = 0;
    a_TDATA = av; b_TDATA = bv; a_TVALID = 1'b1; b_TVALID = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge ap_clk);
      ok = a_TREADY && b_TREADY;
      @(posedge ap_clk); #1;
    end
    a_TVALID = 1'b0; b_TVALID = 1'b0;
    if (!ok) timeout("ab_handshake");
  endtask

  task automatic send_c(input logic [31:0] cv);
    bit ok;
    ok = 0;
    c_TDATA = cv; c_TVALID = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge ap_clk);
      ok = c_TREADY;
      @(posedge ap_clk); #1;
    end
    c_TVALID = 1'b0;
    if (!ok) timeout("c_handshake");
  endtask

  task automatic wait_done(input string nm, input int exp_cnt);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge ap_clk);
      if (done_o) begin
        seen = 1;
        check({nm, "_busy_low"}, 64'(busy_o), 64'd0);
        check({nm, "_cnt"}, 64'(cnt_o), 64'(exp_cnt));
        check({nm, "_all_results"}, 64'(exp_q.size()), 64'd0);
      end
      @(posedge ap_clk); #1;
    end
    if (!seen) timeout({nm, "_done"});
    else begin
      @(negedge ap_clk);
      check({nm, "_done_pulse"}, 64'(done_o), 64'd0);
      @(posedge ap_clk); #1;
    end
  endtask

  // Output backpressure window relative to the start acceptance cycle
  initial forever begin
    @(posedge ap_clk); #2;
    d_TREADY = !(stall_en && (cyc - t0) >= 4 && (cyc - t0) <= 13);
  end

  // Scoreboard: every d handshake pops the next expected value; stalled d must hold
  initial begin
    bit          prev_stall;
    logic [31:0] prev_dat;
    logic [31:0] exp_v;
    prev_stall = 0;
    prev_dat   = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("d_hold_vld", 64'(d_TVALID), 64'd1);
          check("d_hold_dat", 64'(d_TDATA), 64'(prev_dat));
        end
        if (d_TVALID && d_TREADY) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL d_unexpected: got 0x%0h, expected no beat", d_TDATA);
          end else begin
            exp_v = exp_q.pop_front();
            check("d_data", 64'(d_TDATA), 64'(exp_v));
          end
        end
        if (stall_en && a_TVALID && !a_TREADY && busy_o) stall_cnt++;
        prev_stall = d_TVALID && !d_TREADY;
        prev_dat   = d_TDATA;
      end
    end
  end

  initial begin
    logic [127:0] av[8];
    logic [127:0] bv[8];
    logic [127:0] ones7f;
    logic [31:0]  la, lb;
    bit           any_rdy;

    ap_rst_n = 1'b0; start = 1'b0; reg_clear = 1'b0; reg_mode = 1'b0; reg_sat = 1'b0;
    reg_shift = '0; reg_len = '0; a_TVALID = 1'b0; b_TVALID = 1'b0; a_TDATA = '0; b_TDATA = '0;
    c_TVALID = 1'b0; c_TDATA = '0; d_TREADY = 1'b1;
    ones7f = {4{32'h7FFF_FFFF}};

    repeat (2) @(posedge ap_clk); #1;
    check("rst_a_rdy", 64'(a_TREADY), 64'd0);
    check("rst_b_rdy", 64'(b_TREADY), 64'd0);
    check("rst_c_rdy", 64'(c_TREADY), 64'd0);
    check("rst_d_vld", 64'(d_TVALID), 64'd0);
    check("rst_d_dat", 64'(d_TDATA), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cnt", 64'(cnt_o), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // DOT, two beats, plus a start pulse mid-job that must be ignored
    exp_q.push_back(32'd70);
    exp_q.push_back(32'hFFFF_FFF8);
    pulse_start(1'b0, 1'b0, 0, 2);
    check("dot_busy", 64'(busy_o), 64'd1);
    send_ab({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
    pulse_start(1'b1, 1'b0, 0, 7);
    send_ab({4{32'hFFFF_FFFF}}, {4{32'd2}});
    wait_done("dot", 2);

    // ACC: seed 1<<<4 = 16, plus 3*16 = 64, output 64>>>4 = 4; a/b offered early
    exp_q.push_back(32'd4);
    pulse_start(1'b1, 1'b0, 4, 3);
    fork
      send_c(32'd1);
      begin
        repeat (3) send_ab({96'd0, 32'd1}, {96'd0, 32'd16});
      end
    join
    wait_done("acc", 3);

    // Overflowing dot product: clamp vs truncate
    exp_q.push_back(32'h7FFF_FFFF);
    pulse_start(1'b0, 1'b1, 0, 1);
    send_ab(ones7f, ones7f);
    wait_done("sat1", 1);
    exp_q.push_back(32'h0000_0004);
    pulse_start(1'b0, 1'b0, 0, 1);
    send_ab(ones7f, ones7f);
    wait_done("sat0", 1);

    // Eight beats through a d_TREADY stall window; expectations from the model
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        la = 32'(k * 1234567 + i * 7654321) - 32'h4000_0000;
        lb = 32'h8000_0001 + 32'(k * 99991) * 32'(i + 1);
        av[k][i*32 +: 32] = la;
        bv[k][i*32 +: 32] = lb;
      end
      exp_q.push_back(model_d(av[k], bv[k], 2, 1'b0));
    end
    pulse_start(1'b0, 1'b0, 2, 8);
    stall_en  = 1'b1;
    stall_cnt = 0;
    for (int k = 0; k < 8; k++) send_ab(av[k], bv[k]);
    wait_done("stall", 8);
    stall_en = 1'b0;
    check("ab_stalled", 64'(stall_cnt > 0), 64'd1);

    // Abort ACC job with reg_clear, then a fresh DOT job
    pulse_start(1'b1, 1'b0, 0, 5);
    send_c(32'd3);
    send_ab({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
    send_ab({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
    check("clr_cnt_before", 64'(cnt_o), 64'd2);
    reg_clear = 1'b1;
    @(posedge ap_clk); #1;
    reg_clear = 1'b0;
    check("clr_busy", 64'(busy_o), 64'd0);
    check("clr_cnt", 64'(cnt_o), 64'd0);
    check("clr_d_vld", 64'(d_TVALID), 64'd0);
    repeat (6) @(posedge ap_clk); #1;
    check("clr_idle", 64'(busy_o), 64'd0);
    exp_q.push_back(32'd70);
    exp_q.push_back(32'hFFFF_FFF8);
    pulse_start(1'b0, 1'b0, 0, 2);
    send_ab({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
    send_ab({4{32'hFFFF_FFFF}}, {4{32'd2}});
    wait_done("clr_dot", 2);

    // Same abort via asynchronous reset
    pulse_start(1'b1, 1'b0, 0, 5);
    send_c(32'd3);
    send_ab({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
    send_ab({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5});
    ap_rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_cnt", 64'(cnt_o), 64'd0);
    check("arst_c_rdy", 64'(c_TREADY), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    repeat (6) @(posedge ap_clk); #1;
    check("arst_idle", 64'(busy_o), 64'd0);
    exp_q.push_back(32'd100);
    pulse_start(1'b0, 1'b0, 0, 1);
    send_ab({32'd40, 32'd30, 32'd20, 32'd10}, {4{32'd1}});
    wait_done("arst_dot", 1);

    // Zero-length job: done two cycles after start, no TREADY at any point
    any_rdy = 0;
    pulse_start(1'b0, 1'b0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge ap_clk);
      any_rdy = any_rdy | a_TREADY | b_TREADY | c_TREADY;
      check("len0_done", 64'(done_o), 64'(j == 1));
      if (j == 0) check("len0_busy", 64'(busy_o), 64'd1);
      @(posedge ap_clk); #1;
    end
    check("len0_no_rdy", 64'(any_rdy), 64'd0);
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
